stopwatch_mod_counter: RTL and testbench
========================================

// Module: stopwatch_mod_counter
// PURPOSE
//  Parametrised modulo-N stopwatch digit-pair counter with its own tick prescaler. It supports up/down
//  counting, synchronous clear, a lap (display-freeze) hold and a cascade tick output. Instances
//  chain as sec -> min -> hour in the stopwatch top. Each instance drives two 7-segment digits.
// PARAMETERS
//  MODULUS   60      count range 0..MODULUS-1; legal 2..100
//  TICK_DIV  250000  clk cycles per count step when INT_TICK=1; legal >=1
//  INT_TICK  1       1: step from internal prescaler; 0: step on tick_in pulses (cascade mode)
//  W         $clog2(MODULUS)  derived width of count (localparam, not overridable)
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  reset      in   1  synchronous, active-high; highest priority
//  enable     in   1  run/stop; when low, prescaler and count hold
//  tick_in    in   1  one-cycle step request; used only when INT_TICK=0
//  dir        in   1  0 = count up, 1 = count down
//  clear      in   1  synchronous zero of count and prescaler
//  lap        in   1  level; 1 freezes display/display10/ones_bcd/tens_bcd, count keeps running
//  count      out  W  binary count value, registered
//  ones_bcd   out  4  ones digit of displayed value
//  tens_bcd   out  4  tens digit of displayed value
//  display    out  7  ones 7-seg, active-low, bit6..0 = a..g (0 -> 7'b000_0001)
//  display10  out  7  tens 7-seg, same encoding
//  tc         out  1  combinational terminal-count pulse for cascading
// BEHAVIOUR
//  - Reset state: count=0, prescaler=0, internal digits 0/0, ones_bcd=tens_bcd=0,
//    display=display10=7'b000_0001.
//  - Priority each cycle: reset > clear > step.
//  - step: INT_TICK=1 -> enable & (presc==TICK_DIV-1); presc wraps to 0 that cycle, else presc+1 when enabled.
//    INT_TICK=0 -> enable & tick_in; prescaler unused (held 0).
//  - Up step: count==MODULUS-1 -> 0, else +1. Down step: count==0 -> MODULUS-1, else -1.
//  - Internal BCD digit pair is tracked incrementally alongside count (ones 9->0 carries to tens,
//    0->9 borrows). No divide/modulo hardware. Wrap loads 0/0 or the BCD of MODULUS-1.
//  - tc = step & (dir ? count==0 : count==MODULUS-1). High only in the cycle the wrap is taken.
//    Low whenever enable=0, clear=1 or reset=1.
//  - clear: count, digits and prescaler go to 0 next edge. No tc is emitted. Overrides a coincident step.
//  - Display path: ones_bcd/tens_bcd/display/display10 are registered from the internal digits, one cycle after count.
//    While lap=1 they hold their value. On lap 1->0 they show the live value one cycle later.
//    Clear or step during lap changes count only. Reset always clears displays.
//  - dir may change any cycle; it takes effect on the next step. It is not a step itself.
//  - Segment table 0..9: 0000001,1001111,0010010,0000110,1001100,0100100,0100000,0001111,0000000,0000100.
//    Any other code displays 1111111 (blank); it is unreachable.
//  - Mid-operation reset: all state returns to reset values on that edge, regardless of lap/clear/step.
// STRUCTURE
//  - stopwatch_pkg: SEG_BLANK and the 10 digit-pattern constants.
//    Also holds function seg7_of(logic [3:0]) returning the 7-bit pattern.
//  - Sub-module seg7_decode (4-bit BCD in, 7-bit segments out, combinational). Instantiated twice,
//    feeding the display registers.
//  - Prescaler, count/BCD pair and display/lap registers stay in this module.
// TESTING (sims use TICK_DIV=4 unless stated)
//  1. reset 3 cycles, enable=1, dir=0 -> count steps every 4 clks. At count 59 the next step gives
//     count=0, tc=1 for exactly 1 clk, display10/display=000_0001/000_0001.
//  2. dir=1 from count=0 -> wraps to 59, tc pulses 1 clk. A following step gives 58 with tens_bcd=5, ones_bcd=8.
//  3. Count at 37, lap=1 for 20 steps -> display holds 3/7 while count reaches 57.
//     Release lap -> display shows 57 one clk later.
//  4. clear coincident with step at count=59 -> count=0, tc=0, prescaler=0. The next step occurs 4 clks later.
//  5. Cascade: sec (INT_TICK=1) tc -> min (INT_TICK=0, MODULUS=60) tick_in. After 3600 sec steps,
//     min wraps 59->0 with its own tc pulse. MODULUS=24 instance: 23->0.
//  6. enable=0 for 10 clks mid-count -> count, prescaler and tc frozen.
//     reset asserted while lap=1 -> display=7'b000_0001 next edge.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared 7-segment constants and decode helper for the stopwatch digit counters.
package stopwatch_pkg;

  typedef logic [6:0] seg7_t;

  // Active-low segments, bit6..0 = a..g
  localparam seg7_t SEG_BLANK = 7'b111_1111;
  localparam seg7_t SEG_0     = 7'b000_0001;
  localparam seg7_t SEG_1     = 7'b100_1111;
  localparam seg7_t SEG_2     = 7'b001_0010;
  localparam seg7_t SEG_3     = 7'b000_0110;
  localparam seg7_t SEG_4     = 7'b100_1100;
  localparam seg7_t SEG_5     = 7'b010_0100;
  localparam seg7_t SEG_6     = 7'b010_0000;
  localparam seg7_t SEG_7     = 7'b000_1111;
  localparam seg7_t SEG_8     = 7'b000_0000;
  localparam seg7_t SEG_9     = 7'b000_0100;

  function automatic seg7_t seg7_of(input logic [3:0] bcd);
    seg7_t seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
module seg7_decode
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure table lookup
  always_comb begin
    seg = seg7_of(bcd);
  end

endmodule

// File: rtl/stopwatch_mod_counter.sv
// Modulo-N stopwatch digit-pair counter with prescaler, up/down, clear,
// lap-freeze display registers and a combinational cascade terminal count.
module stopwatch_mod_counter
  import stopwatch_pkg::*;
#(
  parameter  int unsigned MODULUS  = 60,
  parameter  int unsigned TICK_DIV = 250000,
  parameter  bit          INT_TICK = 1'b1,
  localparam int unsigned W        = $clog2(MODULUS)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         tick_in,
  input  logic         dir,
  input  logic         clear,
  input  logic         lap,
  output logic [W-1:0] count,
  output logic [3:0]   ones_bcd,
  output logic [3:0]   tens_bcd,
  output logic [6:0]   display,
  output logic [6:0]   display10,
  output logic         tc
);

  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  CNT_MAX = W'(MODULUS - 1);
  // Digits of MODULUS-1, folded at elaboration so no divider is built
  localparam logic [3:0] MAX_ONES = 4'((MODULUS - 1) % 10);
  localparam logic [3:0] MAX_TENS = 4'((MODULUS - 1) / 10);

  logic [PW-1:0] presc;
  logic          step;
  logic          at_wrap;
  logic [3:0]    ones_q;
  logic [3:0]    tens_q;
  seg7_t         seg_ones;
  seg7_t         seg_tens;

  // Step source selection and wrap detection
  always_comb begin
    step    = enable & (INT_TICK ? (presc == PRE_MAX) : tick_in);
    at_wrap = dir ? (count == '0) : (count == CNT_MAX);
    tc      = step & at_wrap & ~clear & ~reset;
  end

  // Prescaler; held at zero in cascade mode
  always_ff @(posedge clk) begin
    if (reset || clear || !INT_TICK) begin
      presc <= '0;
    end else if (enable) begin
      presc <= step ? '0 : presc + PW'(1);
    end
  end

  // Binary count with BCD digit pair tracked incrementally alongside it
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count  <= '0;
      ones_q <= '0;
      tens_q <= '0;
    end else if (step) begin
      if (at_wrap) begin
        count  <= dir ? CNT_MAX  : '0;
        ones_q <= dir ? MAX_ONES : '0;
        tens_q <= dir ? MAX_TENS : '0;
      end else if (dir) begin
        count <= count - W'(1);
        if (ones_q == 4'd0) begin
          ones_q <= 4'd9;
          tens_q <= tens_q - 4'd1;
        end else begin
          ones_q <= ones_q - 4'd1;
        end
      end else begin
        count <= count + W'(1);
        if (ones_q == 4'd9) begin
          ones_q <= 4'd0;
          tens_q <= tens_q + 4'd1;
        end else begin
          ones_q <= ones_q + 4'd1;
        end
      end
    end
  end

  seg7_decode u_seg_ones (.bcd(ones_q), .seg(seg_ones));
  seg7_decode u_seg_tens (.bcd(tens_q), .seg(seg_tens));

  // Display registers follow the live digits unless lap freezes them
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_bcd  <= '0;
      tens_bcd  <= '0;
      display   <= SEG_0;
      display10 <= SEG_0;
    end else if (!lap) begin
      ones_bcd  <= ones_q;
      tens_bcd  <= tens_q;
      display   <= seg_ones;
      display10 <= seg_tens;
    end
  end

endmodule

// File: tb/tb_stopwatch_mod_counter.sv
// Randomized bench: sec (internal tick) cascading into min, plus an
// independent mod-24 cascade-mode instance, all checked against a
// value-level reference model every cycle.
module tb_stopwatch_mod_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [3];
  logic       en  [3];
  logic       tk  [3];
  logic       dr  [3];
  logic       clr [3];
  logic       lp  [3];
  logic [5:0] cnt0, cnt1;
  logic [4:0] cnt2;
  logic [3:0] ones [3];
  logic [3:0] tens [3];
  logic [6:0] dsp  [3];
  logic [6:0] dsp10[3];
  logic       tc   [3];

  stopwatch_mod_counter #(.MODULUS(60), .TICK_DIV(4), .INT_TICK(1'b1)) u_sec (
    .clk(clk), .reset(rst[0]), .enable(en[0]), .tick_in(tk[0]), .dir(dr[0]),
    .clear(clr[0]), .lap(lp[0]), .count(cnt0), .ones_bcd(ones[0]), .tens_bcd(tens[0]),
    .display(dsp[0]), .display10(dsp10[0]), .tc(tc[0]));

  stopwatch_mod_counter #(.MODULUS(60), .TICK_DIV(4), .INT_TICK(1'b0)) u_min (
    .clk(clk), .reset(rst[1]), .enable(en[1]), .tick_in(tc[0]), .dir(dr[1]),
    .clear(clr[1]), .lap(lp[1]), .count(cnt1), .ones_bcd(ones[1]), .tens_bcd(tens[1]),
    .display(dsp[1]), .display10(dsp10[1]), .tc(tc[1]));

  stopwatch_mod_counter #(.MODULUS(24), .TICK_DIV(4), .INT_TICK(1'b0)) u_hr (
    .clk(clk), .reset(rst[2]), .enable(en[2]), .tick_in(tk[2]), .dir(dr[2]),
    .clear(clr[2]), .lap(lp[2]), .count(cnt2), .ones_bcd(ones[2]), .tens_bcd(tens[2]),
    .display(dsp[2]), .display10(dsp10[2]), .tc(tc[2]));

  // Reference segment patterns, digits 0..9
  logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                               7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  int unsigned cyc   = 0;

  // Model state: counted value, prescaler phase, value shown on the display
  int  mod_n   [3] = '{60, 60, 24};
  bit  int_tk  [3] = '{1'b1, 1'b0, 1'b0};
  int  m_cnt   [3];
  int  m_presc [3];
  int  m_disp  [3];
  bit  e_step  [3];
  bit  e_tc    [3];

  int  dut_min_tc = 0;
  int  mdl_min_tc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int dut_cnt(input int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("count%0d", i), dut_cnt(i), m_cnt[i]);
      chk($sformatf("ones_bcd%0d", i), int'(ones[i]), m_disp[i] % 10);
      chk($sformatf("tens_bcd%0d", i), int'(tens[i]), m_disp[i] / 10);
      chk($sformatf("display%0d", i), int'(dsp[i]), int'(seg_tab[m_disp[i] % 10]));
      chk($sformatf("display10_%0d", i), int'(dsp10[i]), int'(seg_tab[m_disp[i] / 10]));
    end
  endtask

  // Expected step/tc from the current model state and the applied inputs
  task automatic model_eval();
    for (int i = 0; i < 3; i++) begin
      bit tick;
      bit wrap;
      tick      = (i == 1) ? e_tc[0] : tk[i];
      e_step[i] = en[i] && (int_tk[i] ? (m_presc[i] == 3) : tick);
      wrap      = dr[i] ? (m_cnt[i] == 0) : (m_cnt[i] == mod_n[i] - 1);
      e_tc[i]   = e_step[i] && wrap && !clr[i] && !rst[i];
    end
  endtask

  task automatic model_clock();
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) begin
        m_cnt[i] = 0; m_presc[i] = 0; m_disp[i] = 0;
      end else begin
        if (!lp[i]) m_disp[i] = m_cnt[i];
        if (clr[i]) begin
          m_cnt[i] = 0; m_presc[i] = 0;
        end else begin
          if (int_tk[i] && en[i]) m_presc[i] = e_step[i] ? 0 : m_presc[i] + 1;
          if (e_step[i])
            m_cnt[i] = dr[i] ? (m_cnt[i] + mod_n[i] - 1) % mod_n[i] : (m_cnt[i] + 1) % mod_n[i];
        end
      end
    end
  endtask

  task automatic drive(input int phase);
    // min counter: free-running up counter fed only by sec tc
    rst[1] = (cyc < 3); en[1] = 1'b1; tk[1] = 1'b0; dr[1] = 1'b0; clr[1] = 1'b0;
    if ($urandom_range(29) == 0) lp[1] = ~lp[1];
    // hour counter: fully random cascade-mode traffic
    rst[2] = (cyc < 3) || ($urandom_range(499) == 0);
    en[2]  = ($urandom_range(9) != 0);
    tk[2]  = $urandom_range(1) == 1;
    clr[2] = ($urandom_range(99) == 0);
    if ($urandom_range(29) == 0) dr[2] = ~dr[2];
    if ($urandom_range(19) == 0) lp[2] = ~lp[2];
    // sec counter: random in phase 0, steady up-count in phase 1
    tk[0] = $urandom_range(1) == 1;
    if ($urandom_range(39) == 0) lp[0] = ~lp[0];
    if (phase == 0) begin
      rst[0] = (cyc < 3) || ($urandom_range(999) == 0);
      en[0]  = ($urandom_range(9) != 0);
      clr[0] = ($urandom_range(149) == 0);
      if ($urandom_range(199) == 0) dr[0] = ~dr[0];
    end else begin
      rst[0] = 1'b0; en[0] = 1'b1; clr[0] = 1'b0; dr[0] = 1'b0;
    end
  endtask

  task automatic run_cycles(input int phase, input int n);
    for (int k = 0; k < n; k++) begin
      drive(phase);
      #1;
      model_eval();
      for (int i = 0; i < 3; i++) chk($sformatf("tc%0d", i), int'(tc[i]), int'(e_tc[i]));
      if (phase == 1) begin
        if (tc[1]) dut_min_tc++;
        if (e_tc[1]) mdl_min_tc++;
      end
      model_clock();
      @(negedge clk);
      cyc++;
      check_outputs();
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; tk[i] = 1'b0; dr[i] = 1'b0; clr[i] = 1'b0; lp[i] = 1'b0;
      m_cnt[i] = 0; m_presc[i] = 0; m_disp[i] = 0; e_step[i] = 1'b0; e_tc[i] = 1'b0;
    end
    run_cycles(0, 8000);
    // 3750 sec steps guarantee at least one min wrap regardless of start value
    run_cycles(1, 15000);
    chk("min_tc_pulses", dut_min_tc, mdl_min_tc);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
